// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, base opcodes (including HALT) and fetch FSM states.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [6:0] {
        OpLoad   = 7'b0000011,
        OpImm    = 7'b0010011,
        OpStore  = 7'b0100011,
        OpReg    = 7'b0110011,
        OpLui    = 7'b0110111,
        OpBranch = 7'b1100011,
        OpJalr   = 7'b1100111,
        OpJal    = 7'b1101111,
        HALT     = 7'b1111111
    } opcode_t;

    typedef enum logic [1:0] {
        StRun,
        StDiscard,
        StHalted
    } fetch_state_e;

    localparam word_t InstrStep = 32'd4;

    function automatic word_t align_word(input word_t addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_if.sv
// IF/ID pipeline bundle shared between the fetch stage and decode.
interface if_fetch_if;
    import cpu_types_pkg::*;

    word_t instr;
    word_t pc;
    word_t npc;
    logic  valid;

    modport fetch  (output instr, pc, npc, valid);
    modport decode (input  instr, pc, npc, valid);

endinterface

// File: rtl/if_id_reg.sv
// IF/ID latch: load a new fetch, insert a bubble, or hold the current contents.
module if_id_reg
    import cpu_types_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  load_i,
    input  logic  bubble_i,
    input  word_t instr_i,
    input  word_t pc_i,
    input  word_t npc_i,
    if_fetch_if.fetch ifid
);

    word_t instr_q;
    word_t pc_q;
    word_t npc_q;
    logic  valid_q;

    // Bubble wins over load; pc/npc are left as-is on a bubble since valid=0 masks them.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            instr_q <= '0;
            pc_q    <= '0;
            npc_q   <= '0;
            valid_q <= 1'b0;
        end else if (bubble_i) begin
            instr_q <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            instr_q <= instr_i;
            pc_q    <= pc_i;
            npc_q   <= npc_i;
            valid_q <= 1'b1;
        end
    end

    assign ifid.instr = instr_q;
    assign ifid.pc    = pc_q;
    assign ifid.npc   = npc_q;
    assign ifid.valid = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, miss/redirect FSM and the IF/ID latch.
module fetch_stage
    import cpu_types_pkg::*;
#(
    parameter word_t RESET_PC = 32'h0000_0000
) (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  ihit,
    input  word_t iload,
    output logic  iREN,
    output word_t iaddr,
    input  logic  stall,
    input  logic  flush,
    input  word_t redirect_pc,
    output word_t instr_q,
    output word_t pc_q,
    output word_t npc_q,
    output logic  valid_q
);

    fetch_state_e state_q, state_d;
    word_t        pc_reg_q, pc_reg_d;
    word_t        pend_q, pend_d;
    logic         ifid_load;
    logic         ifid_bubble;
    logic         miss_pending;
    word_t        pc_plus4;

    if_fetch_if ifid ();

    assign pc_plus4     = pc_reg_q + InstrStep;
    assign iaddr        = pc_reg_q;
    assign iREN         = nRST && (state_q != StHalted) && !stall;
    assign miss_pending = iREN && !ihit;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q  <= StRun;
            pc_reg_q <= RESET_PC;
            pend_q   <= '0;
        end else begin
            state_q  <= state_d;
            pc_reg_q <= pc_reg_d;
            pend_q   <= pend_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_reg_d    = pc_reg_q;
        pend_d      = pend_q;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;

        if (flush) begin
            ifid_bubble = 1'b1;
            // An in-flight miss must complete at the old address; park the target.
            if (miss_pending) begin
                pend_d  = align_word(redirect_pc);
                state_d = StDiscard;
            end else begin
                pc_reg_d = align_word(redirect_pc);
                state_d  = StRun;
            end
        end else if (!stall) begin
            unique case (state_q)
                StRun: begin
                    if (ihit) begin
                        ifid_load = 1'b1;
                        if (iload[6:0] == HALT) begin
                            state_d = StHalted;
                        end else begin
                            pc_reg_d = pc_plus4;
                        end
                    end else begin
                        ifid_bubble = 1'b1;
                    end
                end
                StDiscard: begin
                    ifid_bubble = 1'b1;
                    if (ihit) begin
                        pc_reg_d = pend_q;
                        state_d  = StRun;
                    end
                end
                StHalted: begin
                end
                default: begin
                    state_d = StRun;
                end
            endcase
        end
    end

    if_id_reg u_if_id_reg (
        .clk_i    (CLK),
        .rst_ni   (nRST),
        .load_i   (ifid_load),
        .bubble_i (ifid_bubble),
        .instr_i  (iload),
        .pc_i     (pc_reg_q),
        .npc_i    (pc_plus4),
        .ifid     (ifid)
    );

    assign instr_q = ifid.instr;
    assign pc_q    = ifid.pc;
    assign npc_q   = ifid.npc;
    assign valid_q = ifid.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming fetch, stall, miss+redirect, halt, wrap, reset.
module tb_fetch_stage;
    import cpu_types_pkg::*;

    logic  CLK = 1'b0;
    logic  nRST;
    logic  ihit;
    word_t iload;
    logic  iREN;
    word_t iaddr;
    logic  stall;
    logic  flush;
    word_t redirect_pc;
    word_t instr_q;
    word_t pc_q;
    word_t npc_q;
    logic  valid_q;

    int n_checks = 0;
    int n_fail   = 0;

    localparam word_t Addi = 32'h0050_0093;
    localparam word_t Jal  = 32'hDEAD_BEEF;
    localparam word_t Halt = 32'hFFFF_FFFF;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .ihit        (ihit),
        .iload       (iload),
        .iREN        (iREN),
        .iaddr       (iaddr),
        .stall       (stall),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .instr_q     (instr_q),
        .pc_q        (pc_q),
        .npc_q       (npc_q),
        .valid_q     (valid_q)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        nRST = 1'b0; ihit = 1'b0; iload = '0; stall = 1'b0; flush = 1'b0; redirect_pc = '0;
        tick();
        tick();
        chk("rst_valid", 32'(valid_q), 32'd0);
        chk("rst_instr", instr_q, 32'h0);
        chk("rst_pc_q", pc_q, 32'h0);
        chk("rst_npc_q", npc_q, 32'h0);
        chk("rst_iaddr", iaddr, 32'h0);
        chk("rst_iren", 32'(iREN), 32'd0);

        // Streaming hits
        nRST = 1'b1;
        #1;
        chk("first_iren", 32'(iREN), 32'd1);
        ihit = 1'b1; iload = Addi;
        tick();
        chk("hit0_pc_q", pc_q, 32'h0);
        chk("hit0_npc_q", npc_q, 32'h4);
        chk("hit0_instr", instr_q, Addi);
        chk("hit0_valid", 32'(valid_q), 32'd1);
        tick();
        chk("hit1_pc_q", pc_q, 32'h4);
        tick();
        chk("hit2_pc_q", pc_q, 32'h8);
        chk("hit2_iaddr", iaddr, 32'hC);

        // Stall holds everything
        stall = 1'b1;
        #1;
        chk("stall_iren", 32'(iREN), 32'd0);
        tick();
        tick();
        chk("stall_pc_q", pc_q, 32'h8);
        chk("stall_instr", instr_q, Addi);
        chk("stall_iaddr", iaddr, 32'hC);
        stall = 1'b0;
        tick();
        chk("resume_pc_q", pc_q, 32'hC);
        chk("resume_iaddr", iaddr, 32'h10);

        // Miss at 0x10, flush during the miss, late ihit
        ihit = 1'b0;
        tick();
        chk("miss_valid", 32'(valid_q), 32'd0);
        chk("miss_instr", instr_q, 32'h0);
        chk("miss_iaddr", iaddr, 32'h10);
        flush = 1'b1; redirect_pc = 32'h103;
        #1;
        chk("miss_iren", 32'(iREN), 32'd1);
        tick();
        chk("flush_iaddr", iaddr, 32'h10);
        chk("flush_state", 32'(dut.state_q), 32'(StDiscard));
        flush = 1'b0;
        tick();
        chk("discard_iaddr", iaddr, 32'h10);
        ihit = 1'b1; iload = Jal;
        tick();
        chk("drop_valid", 32'(valid_q), 32'd0);
        chk("drop_instr", instr_q, 32'h0);
        chk("redir_iaddr", iaddr, 32'h100);
        iload = Addi;
        tick();
        chk("redir_pc_q", pc_q, 32'h100);
        chk("redir_valid", 32'(valid_q), 32'd1);
        chk("redir_iaddr2", iaddr, 32'h104);

        // Halt at 0x20
        flush = 1'b1; redirect_pc = 32'h20;
        tick();
        chk("to20_iaddr", iaddr, 32'h20);
        chk("to20_valid", 32'(valid_q), 32'd0);
        flush = 1'b0; iload = Halt;
        tick();
        chk("halt_valid", 32'(valid_q), 32'd1);
        chk("halt_instr", instr_q, Halt);
        chk("halt_pc_q", pc_q, 32'h20);
        chk("halt_iaddr", iaddr, 32'h20);
        chk("halt_state", 32'(dut.state_q), 32'(StHalted));
        chk("halt_iren", 32'(iREN), 32'd0);
        iload = Addi;
        tick();
        chk("halted_instr", instr_q, Halt);
        chk("halted_iaddr", iaddr, 32'h20);
        ihit = 1'b0; flush = 1'b1; redirect_pc = 32'h40;
        tick();
        flush = 1'b0;
        #1;
        chk("unhalt_iaddr", iaddr, 32'h40);
        chk("unhalt_iren", 32'(iREN), 32'd1);
        chk("unhalt_valid", 32'(valid_q), 32'd0);
        ihit = 1'b1;
        tick();
        chk("unhalt_pc_q", pc_q, 32'h40);
        chk("unhalt_fetch", 32'(valid_q), 32'd1);

        // PC wrap
        flush = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        tick();
        chk("wrap_iaddr0", iaddr, 32'hFFFF_FFFC);
        flush = 1'b0;
        tick();
        chk("wrap_pc_q", pc_q, 32'hFFFF_FFFC);
        chk("wrap_npc_q", npc_q, 32'h0);
        chk("wrap_iaddr", iaddr, 32'h0);

        // Reset while in DISCARD with flush asserted
        ihit = 1'b0;
        tick();
        flush = 1'b1; redirect_pc = 32'h200;
        tick();
        chk("pre_rst_state", 32'(dut.state_q), 32'(StDiscard));
        nRST = 1'b0; redirect_pc = 32'h300; ihit = 1'b1; stall = 1'b1;
        tick();
        chk("rst2_iaddr", iaddr, 32'h0);
        chk("rst2_valid", 32'(valid_q), 32'd0);
        chk("rst2_state", 32'(dut.state_q), 32'(StRun));
        chk("rst2_iren", 32'(iREN), 32'd0);
        nRST = 1'b1; flush = 1'b0; stall = 1'b0; ihit = 1'b0;
        #1;
        chk("rst2_req", 32'(iREN), 32'd1);
        tick();
        chk("rst2_hold_iaddr", iaddr, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
